// File: rtl/level_sequencer.sv
// Game-flow controller: sequences start, per-level banner, play, win and game-over,
// and publishes the current level, lives, enemy speed and phase flags (all registered).
module level_sequencer #(
    parameter int unsigned MAX_LEVEL     = 5,
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned BANNER_FRAMES = 120,
    parameter int unsigned BASE_SPEED    = 2,
    parameter int unsigned SPEED_STEP    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       gameStart,
    input  logic       levelCleared,
    input  logic       playerDied,
    output logic [2:0] level,
    output logic [2:0] lives,
    output logic [7:0] enemySpeed,
    output logic       levelLoad,
    output logic       levelTransition,
    output logic       gamePlaying,
    output logic       gameWon,
    output logic       gameOver
);

    localparam int unsigned LW = 3;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_BANNER = 3'd2,
        S_PLAY   = 3'd3,
        S_WON    = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t          state_q, state_n;
    logic [LW-1:0]   level_n, lives_n;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_n;

    logic [7:0]      speed_n;
    logic            load_n, transition_n, playing_n, won_n, over_n;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            level           <= LW'(1);
            lives           <= LW'(INIT_LIVES);
            frame_cnt_q     <= '0;
            enemySpeed      <= 8'(BASE_SPEED);
            levelLoad       <= 1'b0;
            levelTransition <= 1'b0;
            gamePlaying     <= 1'b0;
            gameWon         <= 1'b0;
            gameOver        <= 1'b0;
        end else begin
            state_q         <= state_n;
            level           <= level_n;
            lives           <= lives_n;
            frame_cnt_q     <= frame_cnt_n;
            enemySpeed      <= speed_n;
            levelLoad       <= load_n;
            levelTransition <= transition_n;
            gamePlaying     <= playing_n;
            gameWon         <= won_n;
            gameOver        <= over_n;
        end
    end

    // Next state plus level/lives/frame-counter updates
    always_comb begin
        state_n     = state_q;
        level_n     = level;
        lives_n     = lives;
        frame_cnt_n = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (gameStart) state_n = S_LOAD;
            end
            S_LOAD: begin
                frame_cnt_n = '0;
                state_n     = S_BANNER;
            end
            S_BANNER: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == CW'(BANNER_FRAMES - 1)) begin
                        frame_cnt_n = '0;
                        state_n     = S_PLAY;
                    end else begin
                        frame_cnt_n = frame_cnt_q + CW'(1);
                    end
                end
            end
            S_PLAY: begin
                // A death outranks a simultaneous board clear
                if (playerDied) begin
                    if (lives > LW'(1)) begin
                        lives_n = lives - LW'(1);
                        state_n = S_LOAD;
                    end else begin
                        lives_n = '0;
                        state_n = S_OVER;
                    end
                end else if (levelCleared) begin
                    if (level < LW'(MAX_LEVEL)) begin
                        level_n = level + LW'(1);
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_WON;
                    end
                end
            end
            S_WON, S_OVER: begin
                if (gameStart) begin
                    level_n = LW'(1);
                    lives_n = LW'(INIT_LIVES);
                    state_n = S_LOAD;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next-state registers
    always_comb begin
        load_n       = (state_n == S_LOAD);
        transition_n = (state_n == S_BANNER);
        playing_n    = (state_n == S_PLAY);
        won_n        = (state_n == S_WON);
        over_n       = (state_n == S_OVER);
        speed_n      = 8'(BASE_SPEED) + 8'(level_n - LW'(1)) * 8'(SPEED_STEP);
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed game scenarios plus random
// pulses, every cycle compared against a phase-level reference model.
module tb_level_sequencer;

    localparam int unsigned MAX_L  = 5;
    localparam int unsigned INIT_L = 3;
    localparam int unsigned BF     = 3;
    localparam int unsigned BASE   = 2;
    localparam int unsigned STEP   = 1;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, gameStart, levelCleared, playerDied;
    logic [2:0] level, lives;
    logic [7:0] enemySpeed;
    logic       levelLoad, levelTransition, gamePlaying, gameWon, gameOver;

    always #5 clk = ~clk;

    level_sequencer #(
        .MAX_LEVEL(MAX_L), .INIT_LIVES(INIT_L), .BANNER_FRAMES(BF),
        .BASE_SPEED(BASE), .SPEED_STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameStart(gameStart),
        .levelCleared(levelCleared), .playerDied(playerDied),
        .level(level), .lives(lives), .enemySpeed(enemySpeed),
        .levelLoad(levelLoad), .levelTransition(levelTransition),
        .gamePlaying(gamePlaying), .gameWon(gameWon), .gameOver(gameOver)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: game phase by name, frames seen in the current banner
    string m_phase = "idle";
    int    m_level = 1;
    int    m_lives = INIT_L;
    int    m_frames = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic sof, input logic gs,
                              input logic lc, input logic pd);
        if (r) begin
            m_phase = "idle"; m_level = 1; m_lives = INIT_L; m_frames = 0;
        end else if (m_phase == "idle") begin
            if (gs) m_phase = "load";
        end else if (m_phase == "load") begin
            m_frames = 0;
            m_phase  = "banner";
        end else if (m_phase == "banner") begin
            if (sof) begin
                m_frames++;
                if (m_frames == BF) begin
                    m_frames = 0;
                    m_phase  = "play";
                end
            end
        end else if (m_phase == "play") begin
            if (pd) begin
                if (m_lives > 1) begin m_lives--; m_phase = "load"; end
                else begin m_lives = 0; m_phase = "over"; end
            end else if (lc) begin
                if (m_level < MAX_L) begin m_level++; m_phase = "load"; end
                else m_phase = "won";
            end
        end else begin
            if (gs) begin m_level = 1; m_lives = INIT_L; m_phase = "load"; end
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare every output
    task automatic cycle(input logic r, input logic sof, input logic gs,
                         input logic lc, input logic pd);
        @(negedge clk);
        reset = r; startOfFrame = sof; gameStart = gs; levelCleared = lc; playerDied = pd;
        model_step(r, sof, gs, lc, pd);
        @(posedge clk);
        #1;
        check("level", 32'(level), 32'(m_level));
        check("lives", 32'(lives), 32'(m_lives));
        check("enemySpeed", 32'(enemySpeed), (BASE + (m_level - 1) * STEP) % 256);
        check("levelLoad", 32'(levelLoad), 32'(m_phase == "load"));
        check("levelTransition", 32'(levelTransition), 32'(m_phase == "banner"));
        check("gamePlaying", 32'(gamePlaying), 32'(m_phase == "play"));
        check("gameWon", 32'(gameWon), 32'(m_phase == "won"));
        check("gameOver", 32'(gameOver), 32'(m_phase == "over"));
    endtask

    // From LOAD, pulse frames on alternate cycles (with ignored events in between)
    // until PLAY; counts frame pulses that landed while the banner was shown.
    task automatic run_banner(input string tag);
        int pulses = 0;
        for (int k = 0; k < 60 && !gamePlaying; k++) begin
            logic sof;
            logic junk;
            sof  = k[0];
            junk = (k % 4 == 2);
            if (sof && levelTransition) pulses++;
            cycle(1'b0, sof, junk, junk, junk);
        end
        check({tag, "_reached_play"}, 32'(gamePlaying), 32'd1);
        check({tag, "_banner_frames"}, 32'(pulses), BF);
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; gameStart = 1'b0;
        levelCleared = 1'b0; playerDied = 1'b0;

        // Reset then start
        cycle(1, 1, 1, 1, 1);
        cycle(1, 0, 0, 0, 0);
        check("rst_speed", 32'(enemySpeed), 32'd2);
        cycle(0, 0, 0, 1, 0);
        check("idle_ignores_clear", 32'(levelLoad), 32'd0);
        cycle(0, 0, 1, 0, 0);
        check("start_load", 32'(levelLoad), 32'd1);
        cycle(0, 1, 0, 0, 0);
        check("load_single_cycle", 32'(levelLoad), 32'd0);
        run_banner("start");
        check("play_level", 32'(level), 32'd1);
        check("play_lives", 32'(lives), 32'd3);
        check("play_speed", 32'(enemySpeed), 32'd2);

        // Level progression up to the win
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 0);
            check("up_level", 32'(level), 32'(i + 2));
            check("up_speed", 32'(enemySpeed), 32'(i + 3));
            check("up_load", 32'(levelLoad), 32'd1);
            run_banner("up");
        end
        cycle(0, 0, 0, 1, 0);
        check("won_flag", 32'(gameWon), 32'd1);
        check("won_level", 32'(level), 32'd5);
        cycle(0, 0, 0, 1, 1);
        check("won_holds", 32'(gameWon), 32'd1);

        // Death sequence at level 2
        cycle(0, 0, 1, 0, 0);
        run_banner("restart");
        cycle(0, 0, 0, 1, 0);
        run_banner("lvl2");
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1);
            check("death_lives", 32'(lives), 32'(2 - i));
            check("death_level", 32'(level), 32'd2);
            if (i < 2) run_banner("death");
        end
        check("over_flag", 32'(gameOver), 32'd1);

        // Restart from OVER, reach level 3 with 2 lives, then simultaneous events
        cycle(0, 0, 1, 0, 0);
        check("over_restart_load", 32'(levelLoad), 32'd1);
        check("over_restart_lives", 32'(lives), 32'd3);
        run_banner("r1");
        cycle(0, 0, 0, 1, 0);
        run_banner("r2");
        cycle(0, 0, 0, 1, 0);
        run_banner("r3");
        cycle(0, 0, 0, 0, 1);
        run_banner("r4");
        cycle(0, 0, 0, 1, 1);
        check("simul_lives", 32'(lives), 32'd1);
        check("simul_level", 32'(level), 32'd3);
        check("simul_load", 32'(levelLoad), 32'd1);
        run_banner("r5");

        // Reset mid-banner at level 4
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("midbanner_level", 32'(level), 32'd4);
        cycle(1, 1, 1, 0, 0);
        check("rst_mid_level", 32'(level), 32'd1);
        check("rst_mid_flag", 32'(levelTransition), 32'd0);

        // Random pulses against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
